cla: RTL and testbench
======================

CLA -- requirements
Module: cla

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  8  addend A, unsigned.
REQ-005 b  input  8  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 s  output  8  registered sum bits [7:0].
REQ-008 cout  output  1  registered carry-out (bit 8 of sum).
REQ-009 Port order SHALL be clk, rst_n, a, b, cin, s, cout.

Function
REQ-010 Result SHALL equal {cout,s} = a + b + cin, 9-bit unsigned, no truncation.
REQ-011 Per-bit generate g[i]=a[i]&b[i] and propagate p[i]=a[i]^b[i] SHALL be formed for i=0..7.
REQ-012 Sum bits SHALL be s[i]=p[i]^c[i], with c[0]=cin.
REQ-013 Carries SHALL use two 4-bit lookahead groups (bits 3:0, 7:4); within a group each carry is a flat sum-of-products of g/p and the group carry-in, with no ripple chain.
REQ-014 Each group SHALL produce group generate G=g3|p3g2|p3p2g1|p3p2p1g0 and group propagate P=p3&p2&p1&p0.
REQ-015 Second-level lookahead SHALL give c[4]=G0|P0&cin and cout_next=G1|P1&G0|P1&P0&cin.
REQ-016 a, b, cin SHALL be sampled on the rising clk edge; s and cout SHALL be registered at that edge, giving 1-cycle latency from the sampling edge to valid outputs.
REQ-017 Outputs SHALL hold between edges; input changes between edges SHALL NOT affect s or cout.
REQ-018 A new operand set SHALL be accepted every cycle (throughput 1/cycle); there is no handshake.
REQ-019 Wrap-around: a=255, b=1, cin=0 SHALL give s=0, cout=1. Maximum a=255, b=255, cin=1 SHALL give s=255, cout=1.
REQ-020 No X-propagation from the register stage: after reset, outputs SHALL always be fully defined when inputs are defined.

Reset
REQ-021 rst_n low SHALL force s=8'h00 and cout=0 immediately, independent of clk.
REQ-022 While rst_n is low, outputs SHALL stay zero regardless of clk edges or inputs.
REQ-023 On the first rising clk edge with rst_n high, operands SHALL be sampled normally; outputs SHALL reflect them after that edge.
REQ-024 Reset asserted mid-stream SHALL discard the in-flight result; no result computed before reset SHALL appear after deassertion.

Verification
REQ-025 Reset: rst_n=0 with a=7, b=7, cin=1 -> s=0, cout=0 asynchronously; release, then one edge -> s=15, cout=0.
REQ-026 Directed sums, one per cycle: (0,1,1)->2; (3,2,0)->5; (6,5,1)->12; (2,7,0)->9; (4,8,1)->13; (7,7,1)->15, all cout=0, each visible one edge after being applied.
REQ-027 Carry boundary: (255,1,0)->s=0, cout=1; (255,255,1)->s=255, cout=1; (128,128,0)->s=0, cout=1; (0,0,0)->s=0, cout=0.
REQ-028 Lookahead paths: (15,0,1)->s=16 (group-0 propagate into group 1); (240,16,0)->s=0, cout=1; (255,0,1)->s=0, cout=1 (full propagate chain).
REQ-029 Reset mid-stream: apply (200,100,0), assert rst_n low before the next edge -> outputs 0; deassert and apply (1,1,0) -> s=2, cout=0, never s=44/cout=1.
REQ-030 Randomized check: at least 10000 random (a,b,cin) vectors; each registered result SHALL equal the 9-bit reference sum one cycle later.

Source files
------------

// File: rtl/cla.sv
// 8-bit registered carry-lookahead adder: two flat 4-bit lookahead groups
// joined by a second-level lookahead, result captured in one register stage.
module cla (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   localparam int DATA_W = 8;
   localparam int GRP_W  = 4;

   // Returns {P, G, c3, c2, c1} for one group; every carry is a flat sum of products.
   function automatic logic [4:0] grp_lookahead(input logic [GRP_W-1:0] g,
                                                input logic [GRP_W-1:0] p,
                                                input logic             ci);
      logic c1, c2, c3, gg, pp;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      pp = &p;
      return {pp, gg, c3, c2, c1};
   endfunction

   logic [DATA_W-1:0] g, p, c;
   logic [4:0]        la0, la1;
   logic              grp0_g, grp0_p, grp1_g, grp1_p;
   logic              c4;
   logic [DATA_W-1:0] s_d, s_q;
   logic              cout_d, cout_q;

   always_comb begin
      g = a & b;
      p = a ^ b;

      la0    = grp_lookahead(g[3:0], p[3:0], cin);
      grp0_p = la0[4];
      grp0_g = la0[3];

      // Second-level lookahead: group-1 carry-in and carry-out taken straight from cin.
      c4     = grp0_g | (grp0_p & cin);
      la1    = grp_lookahead(g[7:4], p[7:4], c4);
      grp1_p = la1[4];
      grp1_g = la1[3];
      cout_d = grp1_g | (grp1_p & grp0_g) | (grp1_p & grp0_p & cin);

      c   = {la1[2:0], c4, la0[2:0], cin};
      s_d = p ^ c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
      end
   end

   assign s    = s_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_cla.sv
// Directed and random bench for the registered 8-bit carry-lookahead adder.
module tb_cla;

   logic       clk;
   logic       rst_n;
   logic [7:0] a, b;
   logic       cin;
   logic [7:0] s;
   logic       cout;

   int n_chk  = 0;
   int n_pass = 0;

   cla dut (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .s    (s),
      .cout (cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got {cout,s}=%0d (0x%03h) expected %0d (0x%03h)",
                    tag, got, got, exp, exp);
   endtask

   task automatic apply(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                        input logic [8:0] exp, input string tag);
      @(negedge clk);
      a   = ta;
      b   = tb_;
      cin = tc;
      @(posedge clk);
      #1;
      chk(tag, {cout, s}, exp);
   endtask

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vc;
      logic [8:0] exp;
      string      tag;
   } vec_t;

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{8'd0,   8'd1,   1'b1, 9'd2,   "dir_0_1_1"};
      vecs[1]  = '{8'd3,   8'd2,   1'b0, 9'd5,   "dir_3_2_0"};
      vecs[2]  = '{8'd6,   8'd5,   1'b1, 9'd12,  "dir_6_5_1"};
      vecs[3]  = '{8'd2,   8'd7,   1'b0, 9'd9,   "dir_2_7_0"};
      vecs[4]  = '{8'd4,   8'd8,   1'b1, 9'd13,  "dir_4_8_1"};
      vecs[5]  = '{8'd7,   8'd7,   1'b1, 9'd15,  "dir_7_7_1"};
      vecs[6]  = '{8'd255, 8'd1,   1'b0, 9'h100, "wrap_255_1"};
      vecs[7]  = '{8'd255, 8'd255, 1'b1, 9'h1FF, "max_255_255_1"};
      vecs[8]  = '{8'd128, 8'd128, 1'b0, 9'h100, "msb_128_128"};
      vecs[9]  = '{8'd0,   8'd0,   1'b0, 9'h000, "zero"};
      vecs[10] = '{8'd15,  8'd0,   1'b1, 9'd16,  "grp0_prop"};
      vecs[11] = '{8'd240, 8'd16,  1'b0, 9'h100, "grp1_gen"};
      vecs[12] = '{8'd255, 8'd0,   1'b1, 9'h100, "full_prop"};

      rst_n = 1'b1;
      a     = 8'd7;
      b     = 8'd7;
      cin   = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk("rst_async", {cout, s}, 9'h000);
      @(posedge clk);
      #1 chk("rst_hold_edge", {cout, s}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 chk("rst_release_7_7_1", {cout, s}, 9'd15);

      for (int i = 0; i < 13; i++)
         apply(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].exp, vecs[i].tag);

      // Inputs changing between edges must not reach the outputs.
      #2;
      a   = 8'h5A;
      b   = 8'hA5;
      cin = 1'b0;
      #1 chk("hold_between_edges", {cout, s}, 9'h100);

      // Reset in mid-cycle with (200,100,0) in flight; 300 must never appear.
      @(negedge clk);
      a   = 8'd200;
      b   = 8'd100;
      cin = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_async", {cout, s}, 9'h000);
      @(posedge clk);
      #1 chk("mid_rst_hold", {cout, s}, 9'h000);
      @(negedge clk);
      rst_n = 1'b1;
      a     = 8'd1;
      b     = 8'd1;
      cin   = 1'b0;
      @(posedge clk);
      #1 chk("mid_rst_release_1_1", {cout, s}, 9'd2);

      for (int i = 0; i < 10000; i++) begin
         logic [7:0] ra, rb;
         logic       rc;
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         apply(ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc), "random");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
